// File: rtl/ddr_cmd_pkg.sv
// Shared command codes, FSM state type and error-flag bit positions
// for the DDR command bridge.
package ddr_cmd_pkg;

    localparam logic [3:0] CMD_READ  = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WDATA
    } state_t;

    localparam int ERR_BAD_CMD  = 0;
    localparam int ERR_UNEXP_RD = 1;
    localparam int ERR_TIMEOUT  = 2;

    function automatic logic is_valid_cmd(input logic [3:0] code);
        return (code == CMD_READ) || (code == CMD_WRITE);
    endfunction

endpackage

// File: rtl/ddr_cmd_bridge_if.sv
// Front-end request bus between the request-sorting FIFO (master)
// and the DDR command bridge (slave).
interface ddr_cmd_bridge_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 128
);
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] ddr_address;
    logic [DATA_W-1:0] ddr_wr_data;
    logic              cmd_busy;
    logic [DATA_W-1:0] ddr_rd_data;
    logic              ddr_data_valid;

    modport master (
        output cmd, cmd_valid, ddr_address, ddr_wr_data,
        input  cmd_busy, ddr_rd_data, ddr_data_valid
    );

    modport slave (
        input  cmd, cmd_valid, ddr_address, ddr_wr_data,
        output cmd_busy, ddr_rd_data, ddr_data_valid
    );
endinterface

// File: rtl/ddr_rd_tracker.sv
// Outstanding-read counter: counts issued reads, retires them on return
// and flags returns that arrive with nothing outstanding.
module ddr_rd_tracker #(
    parameter int MAX_RD = 8
) (
    input  logic clk_133M,
    input  logic rst_133M,
    input  logic rd_issue,
    input  logic rd_return,
    output logic ret_ok,
    output logic ret_unexp,
    output logic full_next
);

    localparam int CNT_W = $clog2(MAX_RD) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        ret_ok    = rd_return && (cnt_q != '0);
        ret_unexp = rd_return && (cnt_q == '0);
        cnt_d     = cnt_q;
        if (rd_issue && !ret_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!rd_issue && ret_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
        full_next = (cnt_d == CNT_W'(MAX_RD));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr_cmd_bridge.sv
// Bridges single front-end commands onto the DDR3 controller native
// interface and returns read data in order with one cycle of latency.
module ddr_cmd_bridge
    import ddr_cmd_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 128,
    parameter int MAX_RD    = 8,
    parameter int TIMEOUT   = 1024,
    parameter int BURST_CNT = 1
) (
    input  logic              clk_133M,
    input  logic              rst_133M,
    ddr_cmd_bridge_if.slave   req,
    input  logic              mc_init_done,
    output logic [3:0]        mc_cmd,
    output logic              mc_cmd_valid,
    input  logic              mc_cmd_rdy,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [4:0]        mc_burst_cnt,
    output logic [DATA_W-1:0] mc_write_data,
    input  logic              mc_datain_rdy,
    input  logic [DATA_W-1:0] mc_read_data,
    input  logic              mc_read_data_valid,
    output logic [2:0]        err_flags
);

    localparam int             TMR_W   = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             load, cmd_valid_d, rd_issue, bad_cmd, timeout;
    logic             busy_d, ret_ok, ret_unexp, full_next;

    assign mc_burst_cnt = 5'(BURST_CNT);

    ddr_rd_tracker #(.MAX_RD(MAX_RD)) u_rd_tracker (
        .clk_133M  (clk_133M),
        .rst_133M  (rst_133M),
        .rd_issue  (rd_issue),
        .rd_return (mc_read_data_valid),
        .ret_ok    (ret_ok),
        .ret_unexp (ret_unexp),
        .full_next (full_next)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        load        = 1'b0;
        cmd_valid_d = 1'b0;
        rd_issue    = 1'b0;
        bad_cmd     = 1'b0;
        timeout     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req.cmd_valid && !req.cmd_busy) begin
                    if (is_valid_cmd(req.cmd)) begin
                        load    = 1'b1;
                        timer_d = '0;
                        state_d = ISSUE;
                    end else begin
                        bad_cmd = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mc_cmd_rdy) begin
                    cmd_valid_d = 1'b1;
                    timer_d     = '0;
                    if (mc_cmd == CMD_WRITE) begin
                        state_d = WDATA;
                    end else begin
                        rd_issue = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (timer_q == TMR_MAX) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WDATA: begin
                if (mc_datain_rdy) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_MAX) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy looks at the post-update read count so the last free slot is never over-committed.
    assign busy_d = (state_d != IDLE) || !(mc_init_done && !full_next);

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // NOTE: data/address registers are reset as well because their values are visible at the ports.
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            req.cmd_busy       <= 1'b1;
            req.ddr_rd_data    <= '0;
            req.ddr_data_valid <= 1'b0;
            mc_cmd             <= '0;
            mc_cmd_valid       <= 1'b0;
            mc_addr            <= '0;
            mc_write_data      <= '0;
            err_flags          <= '0;
        end else begin
            req.cmd_busy       <= busy_d;
            mc_cmd_valid       <= cmd_valid_d;
            req.ddr_data_valid <= ret_ok;
            if (ret_ok) begin
                req.ddr_rd_data <= mc_read_data;
            end
            if (load) begin
                mc_cmd        <= req.cmd;
                mc_addr       <= req.ddr_address;
                mc_write_data <= req.ddr_wr_data;
            end
            if (bad_cmd)   err_flags[ERR_BAD_CMD]  <= 1'b1;
            if (ret_unexp) err_flags[ERR_UNEXP_RD] <= 1'b1;
            if (timeout)   err_flags[ERR_TIMEOUT]  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_bridge.sv
// Directed bench for ddr_cmd_bridge with command and read-data scoreboards.
`timescale 1ns/1ps
module tb_ddr_cmd_bridge;
    import ddr_cmd_pkg::*;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 128;
    localparam int MAX_RD  = 8;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_exp_t;

    logic              clk_133M = 1'b0;
    logic              rst_133M = 1'b0;
    logic              mc_init_done, mc_cmd_rdy, mc_datain_rdy, mc_read_data_valid;
    logic [DATA_W-1:0] mc_read_data, mc_write_data;
    logic [3:0]        mc_cmd;
    logic              mc_cmd_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic [4:0]        mc_burst_cnt;
    logic [2:0]        err_flags;

    ddr_cmd_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

    ddr_cmd_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD), .TIMEOUT(TIMEOUT), .BURST_CNT(1)
    ) dut (
        .clk_133M           (clk_133M),
        .rst_133M           (rst_133M),
        .req                (req_if.slave),
        .mc_init_done       (mc_init_done),
        .mc_cmd             (mc_cmd),
        .mc_cmd_valid       (mc_cmd_valid),
        .mc_cmd_rdy         (mc_cmd_rdy),
        .mc_addr            (mc_addr),
        .mc_burst_cnt       (mc_burst_cnt),
        .mc_write_data      (mc_write_data),
        .mc_datain_rdy      (mc_datain_rdy),
        .mc_read_data       (mc_read_data),
        .mc_read_data_valid (mc_read_data_valid),
        .err_flags          (err_flags)
    );

    always #3.75 clk_133M = ~clk_133M;

    int                n_cmp = 0;
    int                n_err = 0;
    int                n_pulse = 0;
    int                exp_pulse = 0;
    cmd_exp_t          cmd_q[$];
    logic [DATA_W-1:0] rd_q[$];
    cmd_exp_t          mon_e;
    logic [DATA_W-1:0] mon_d;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_133M);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (req_if.cmd_busy !== 1'b0 && k < 64) begin
            tick();
            k++;
        end
        chk(tag, req_if.cmd_busy, 0);
    endtask

    // Drives a one-cycle command; returns just after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit expect_pulse);
        cmd_exp_t e;
        wait_ready("ready_before_cmd");
        req_if.cmd         = c;
        req_if.ddr_address = a;
        req_if.ddr_wr_data = d;
        req_if.cmd_valid   = 1'b1;
        if (expect_pulse) begin
            e = '{cmd: c, addr: a, data: d};
            cmd_q.push_back(e);
            exp_pulse++;
        end
        tick();
        req_if.cmd_valid = 1'b0;
    endtask

    always @(negedge clk_133M) begin
        if (mc_cmd_valid === 1'b1) begin
            n_pulse++;
            chk("cmd_pulse_expected", DATA_W'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0) begin
                mon_e = cmd_q.pop_front();
                chk("mc_cmd", DATA_W'(mc_cmd), DATA_W'(mon_e.cmd));
                chk("mc_addr", DATA_W'(mc_addr), DATA_W'(mon_e.addr));
                if (mon_e.cmd == CMD_WRITE) chk("mc_write_data", mc_write_data, mon_e.data);
            end
        end
        if (req_if.ddr_data_valid === 1'b1) begin
            chk("rd_pulse_expected", DATA_W'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                mon_d = rd_q.pop_front();
                chk("ddr_rd_data_sb", req_if.ddr_rd_data, mon_d);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_if.cmd = '0; req_if.cmd_valid = 1'b0; req_if.ddr_address = '0; req_if.ddr_wr_data = '0;
        mc_init_done = 1'b0; mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0;
        mc_read_data = '0; mc_read_data_valid = 1'b0;

        // Reset with the controller still calibrating.
        #1 rst_133M = 1'b1;
        tick(3);
        chk("rst_cmd_busy", req_if.cmd_busy, 1);
        chk("rst_mc_cmd_valid", mc_cmd_valid, 0);
        chk("rst_ddr_data_valid", req_if.ddr_data_valid, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_mc_cmd", mc_cmd, 0);
        chk("rst_mc_write_data", mc_write_data, 0);
        chk("rst_ddr_rd_data", req_if.ddr_rd_data, 0);
        chk("burst_cnt", mc_burst_cnt, 1);
        rst_133M = 1'b0;
        tick(2);
        chk("busy_no_init", req_if.cmd_busy, 1);
        mc_init_done = 1'b1;
        tick(2);
        chk("busy_after_init", req_if.cmd_busy, 0);
        chk("err_after_init", err_flags, 0);

        // Write with delayed cmd_rdy and datain_rdy.
        issue(CMD_WRITE, 25'h0001234, {16{8'hA5}}, 1'b1);
        chk("busy_in_issue", req_if.cmd_busy, 1);
        tick(2);
        chk("no_pulse_before_rdy", mc_cmd_valid, 0);
        mc_cmd_rdy = 1'b1;
        tick();
        mc_cmd_rdy = 1'b0;
        chk("wr_pulse", mc_cmd_valid, 1);
        chk("wr_addr", mc_addr, 25'h0001234);
        tick();
        chk("wr_pulse_one_cycle", mc_cmd_valid, 0);
        chk("busy_in_wdata", req_if.cmd_busy, 1);
        tick();
        mc_datain_rdy = 1'b1;
        tick();
        mc_datain_rdy = 1'b0;
        chk("busy_after_write", req_if.cmd_busy, 0);
        chk("wr_data_held", mc_write_data, {16{8'hA5}});

        // Fill all read slots.
        mc_cmd_rdy = 1'b1;
        for (int i = 0; i < MAX_RD; i++) begin
            issue(CMD_READ, ADDR_W'(32'h100 + i), '0, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("busy_when_full", req_if.cmd_busy, 1);
            tick();
        end
        chk("no_rd_pulse_full", req_if.ddr_data_valid, 0);

        // One return frees a slot, data arrives one cycle later.
        mc_read_data = {16{8'h55}};
        mc_read_data_valid = 1'b1;
        rd_q.push_back({16{8'h55}});
        tick();
        mc_read_data_valid = 1'b0;
        chk("rd_valid_latency", req_if.ddr_data_valid, 1);
        chk("rd_data", req_if.ddr_rd_data, {16{8'h55}});
        chk("busy_after_return", req_if.cmd_busy, 0);
        tick();
        chk("rd_valid_single", req_if.ddr_data_valid, 0);

        // Read issue coinciding with a read return keeps the count at 7.
        issue(CMD_READ, 25'h0000200, '0, 1'b1);
        mc_read_data = {8{16'hC3C3}};
        mc_read_data_valid = 1'b1;
        rd_q.push_back({8{16'hC3C3}});
        tick();
        mc_read_data_valid = 1'b0;
        chk("coincide_valid", req_if.ddr_data_valid, 1);
        chk("coincide_data", req_if.ddr_rd_data, {8{16'hC3C3}});
        chk("coincide_busy", req_if.cmd_busy, 0);
        issue(CMD_READ, 25'h0000201, '0, 1'b1);
        tick();
        chk("count_unchanged_full", req_if.cmd_busy, 1);

        // Drain all eight with back-to-back strobes.
        for (int i = 0; i < MAX_RD; i++) begin
            mc_read_data = {4{32'hD000_0000 + 32'(i)}};
            mc_read_data_valid = 1'b1;
            rd_q.push_back({4{32'hD000_0000 + 32'(i)}});
            tick();
            chk("b2b_valid", req_if.ddr_data_valid, 1);
            chk("b2b_data", req_if.ddr_rd_data, {4{32'hD000_0000 + 32'(i)}});
        end
        mc_read_data_valid = 1'b0;
        tick();
        chk("b2b_end", req_if.ddr_data_valid, 0);

        // Illegal command code, then an unexpected read return.
        issue(4'b0111, 25'h0000300, '0, 1'b0);
        chk("bad_cmd_err", err_flags, 3'b001);
        chk("bad_cmd_not_busy", req_if.cmd_busy, 0);
        tick(3);
        chk("bad_cmd_no_pulse", n_pulse, exp_pulse);
        mc_read_data = {16{8'h77}};
        mc_read_data_valid = 1'b1;
        tick();
        mc_read_data_valid = 1'b0;
        chk("unexp_rd_err", err_flags, 3'b011);
        chk("unexp_rd_no_pulse", req_if.ddr_data_valid, 0);
        tick();
        chk("unexp_rd_no_pulse2", req_if.ddr_data_valid, 0);

        // cmd_rdy held low until timeout.
        mc_cmd_rdy = 1'b0;
        issue(CMD_WRITE, 25'h1FFFFFF, {16{8'h99}}, 1'b0);
        tick(TIMEOUT - 1);
        chk("pre_timeout_err", err_flags, 3'b011);
        chk("pre_timeout_busy", req_if.cmd_busy, 1);
        tick();
        chk("timeout_err", err_flags, 3'b111);
        chk("timeout_idle", req_if.cmd_busy, 0);
        tick(2);
        chk("timeout_no_pulse", n_pulse, exp_pulse);

        // Reset during WDATA with one read outstanding.
        mc_cmd_rdy = 1'b1;
        issue(CMD_READ, 25'h0000042, '0, 1'b1);
        tick();
        issue(CMD_WRITE, 25'h0ABCDEF, {16{8'h3C}}, 1'b1);
        tick(3);
        chk("in_wdata_busy", req_if.cmd_busy, 1);
        rst_133M = 1'b1;
        #1;
        chk("midrst_busy", req_if.cmd_busy, 1);
        chk("midrst_cmd_valid", mc_cmd_valid, 0);
        chk("midrst_err", err_flags, 0);
        chk("midrst_addr", mc_addr, 0);
        chk("midrst_wdata", mc_write_data, 0);
        chk("midrst_cmd", mc_cmd, 0);
        chk("midrst_rd_valid", req_if.ddr_data_valid, 0);
        tick();
        rst_133M = 1'b0;
        wait_ready("ready_after_rst");
        mc_read_data = {16{8'hEE}};
        mc_read_data_valid = 1'b1;
        tick();
        mc_read_data_valid = 1'b0;
        chk("forgotten_rd_no_pulse", req_if.ddr_data_valid, 0);
        chk("forgotten_rd_err", err_flags, 3'b010);

        tick(2);
        chk("rd_q_drained", DATA_W'(rd_q.size()), 0);
        chk("cmd_q_drained", DATA_W'(cmd_q.size()), 0);
        chk("pulse_count", n_pulse, exp_pulse);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
